pulse_sequence_controller: RTL and testbench

- Sequences and configures the Doppler transmit/receive core: owns its ENABLE, freq and four state-boundary values (State0/1/2/R).
- Host writes go into shadow registers. A commit validates them; validated values go to the core at a safe boundary only: start, or the RETRANSMIT pulse in RUN.
- Counts pulse repetitions and runs finite ensembles (N pulses) or continuous mode, with a clean stop at a pulse boundary.

---
 rtl/pulse_sequence_controller_pkg.sv | 33 +++
 rtl/pulse_sequence_controller_cfg_regs.sv | 87 ++++++++
 rtl/pulse_sequence_controller.sv | 147 ++++++++++++++
 tb/tb_pulse_sequence_controller.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_sequence_controller_pkg.sv
// Shared constants for the pulse sequence controller: frequency codes,
// configuration addresses, FSM states and default boundary values.
package pulse_sequence_controller_pkg;

    localparam logic [1:0] FREQ_8MHZ = 2'd0;
    localparam logic [1:0] FREQ_4MHZ = 2'd1;
    localparam logic [1:0] FREQ_2MHZ = 2'd2;

    localparam logic [2:0] ADDR_S0     = 3'd0;
    localparam logic [2:0] ADDR_S1     = 3'd1;
    localparam logic [2:0] ADDR_S2     = 3'd2;
    localparam logic [2:0] ADDR_SR     = 3'd3;
    localparam logic [2:0] ADDR_FREQ   = 3'd4;
    localparam logic [2:0] ADDR_N      = 3'd5;
    localparam logic [2:0] ADDR_RSVD   = 3'd6;
    localparam logic [2:0] ADDR_COMMIT = 3'd7;

    localparam int DEF_S0_VAL = 16;
    localparam int DEF_S1_VAL = 64;
    localparam int DEF_S2_VAL = 512;
    localparam int DEF_SR_VAL = 1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic freq_ok(input logic [1:0] f);
        return (f == FREQ_8MHZ) || (f == FREQ_4MHZ) || (f == FREQ_2MHZ);
    endfunction

endpackage

// File: rtl/pulse_sequence_controller_cfg_regs.sv
// Host-side shadow registers, commit validation, pending-update flag and
// the sticky configuration error flag.
module pulse_sequence_controller_cfg_regs
    import pulse_sequence_controller_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int DEF_S0 = DEF_S0_VAL,
    parameter int DEF_S1 = DEF_S1_VAL,
    parameter int DEF_S2 = DEF_S2_VAL,
    parameter int DEF_SR = DEF_SR_VAL
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cfg_wr_i,
    input  logic [2:0]       cfg_addr_i,
    input  logic [CNT_W-1:0] cfg_wdata_i,
    input  logic             load_i,
    output logic [CNT_W-1:0] sh_s0_o,
    output logic [CNT_W-1:0] sh_s1_o,
    output logic [CNT_W-1:0] sh_s2_o,
    output logic [CNT_W-1:0] sh_sr_o,
    output logic [1:0]       sh_freq_o,
    output logic [CNT_W-1:0] n_o,
    output logic             pending_o,
    output logic             cfg_error_o
);

    logic [CNT_W-1:0] s0_q, s1_q, s2_q, sr_q, n_q;
    logic [1:0]       freq_q;
    logic             pending_q, pending_d;
    logic             err_q, err_d;
    logic             valid;

    assign valid = (s0_q != '0) && (s0_q < s1_q) && (s1_q < s2_q) &&
                   (s2_q < sr_q) && freq_ok(freq_q);

    // A commit overrides a same-cycle load so it survives to the next boundary.
    always_comb begin
        pending_d = pending_q;
        err_d     = err_q;
        if (load_i)
            pending_d = 1'b0;
        if (cfg_wr_i && cfg_addr_i == ADDR_RSVD)
            err_d = 1'b1;
        if (cfg_wr_i && cfg_addr_i == ADDR_COMMIT) begin
            pending_d = valid;
            err_d     = !valid;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s0_q      <= CNT_W'(DEF_S0);
            s1_q      <= CNT_W'(DEF_S1);
            s2_q      <= CNT_W'(DEF_S2);
            sr_q      <= CNT_W'(DEF_SR);
            freq_q    <= FREQ_8MHZ;
            n_q       <= '0;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            err_q     <= err_d;
            if (cfg_wr_i) begin
                case (cfg_addr_i)
                    ADDR_S0:   s0_q   <= cfg_wdata_i;
                    ADDR_S1:   s1_q   <= cfg_wdata_i;
                    ADDR_S2:   s2_q   <= cfg_wdata_i;
                    ADDR_SR:   sr_q   <= cfg_wdata_i;
                    ADDR_FREQ: freq_q <= cfg_wdata_i[1:0];
                    ADDR_N:    n_q    <= cfg_wdata_i;
                    default: ;
                endcase
            end
        end
    end

    assign sh_s0_o     = s0_q;
    assign sh_s1_o     = s1_q;
    assign sh_s2_o     = s2_q;
    assign sh_sr_o     = sr_q;
    assign sh_freq_o   = freq_q;
    assign n_o         = n_q;
    assign pending_o   = pending_q;
    assign cfg_error_o = err_q;

endmodule

// File: rtl/pulse_sequence_controller.sv
// Sequences the Doppler transmit/receive core: ensemble/continuous pulse runs,
// pulse counting and safe-boundary application of committed configuration.
//   state | meaning
//   IDLE  | core disabled, waiting for start
//   RUN   | core enabled, counting RETRANSMIT pulses
//   DONE  | ensemble of N pulses complete, one-cycle done strobe
module pulse_sequence_controller
    import pulse_sequence_controller_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int DEF_S0 = DEF_S0_VAL,
    parameter int DEF_S1 = DEF_S1_VAL,
    parameter int DEF_S2 = DEF_S2_VAL,
    parameter int DEF_SR = DEF_SR_VAL
) (
    input  logic             coreClock,
    input  logic             RESET,
    input  logic             cfg_wr,
    input  logic [2:0]       cfg_addr,
    input  logic [CNT_W-1:0] cfg_wdata,
    input  logic             start,
    input  logic             stop,
    input  logic             RETRANSMIT,
    output logic             ENABLE,
    output logic [1:0]       freq,
    output logic [CNT_W-1:0] State0Value,
    output logic [CNT_W-1:0] State1Value,
    output logic [CNT_W-1:0] State2Value,
    output logic [CNT_W-1:0] StateRValue,
    output logic             busy,
    output logic             ensemble_done,
    output logic             cfg_error,
    output logic [CNT_W-1:0] pulse_count
);

    state_e           state_q, state_d;
    logic             enable_q, busy_q, done_q;
    logic             stop_pend_q, stop_pend_d;
    logic [CNT_W-1:0] count_q, count_d, count_inc;
    logic [CNT_W-1:0] act_s0_q, act_s1_q, act_s2_q, act_sr_q;
    logic [1:0]       act_freq_q;
    logic             load;
    logic [CNT_W-1:0] sh_s0, sh_s1, sh_s2, sh_sr, n_val;
    logic [1:0]       sh_freq;
    logic             pending;

    pulse_sequence_controller_cfg_regs #(
        .CNT_W (CNT_W),
        .DEF_S0(DEF_S0),
        .DEF_S1(DEF_S1),
        .DEF_S2(DEF_S2),
        .DEF_SR(DEF_SR)
    ) u_cfg (
        .clk_i      (coreClock),
        .rst_i      (RESET),
        .cfg_wr_i   (cfg_wr),
        .cfg_addr_i (cfg_addr),
        .cfg_wdata_i(cfg_wdata),
        .load_i     (load),
        .sh_s0_o    (sh_s0),
        .sh_s1_o    (sh_s1),
        .sh_s2_o    (sh_s2),
        .sh_sr_o    (sh_sr),
        .sh_freq_o  (sh_freq),
        .n_o        (n_val),
        .pending_o  (pending),
        .cfg_error_o(cfg_error)
    );

    assign count_inc = (count_q == '1) ? count_q : count_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        stop_pend_d = stop_pend_q;
        load        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stop_pend_d = 1'b0;
                if (start && !stop) begin
                    load    = pending;
                    count_d = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop)
                    stop_pend_d = 1'b1;
                if (RETRANSMIT) begin
                    count_d = count_inc;
                    if (n_val != '0 && count_inc == n_val) begin
                        state_d     = ST_DONE;
                        stop_pend_d = 1'b0;
                    end else if (stop_pend_q || stop) begin
                        state_d     = ST_IDLE;
                        stop_pend_d = 1'b0;
                    end else begin
                        load = pending;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so they stay registered.
    always_ff @(posedge coreClock) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            enable_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            count_q     <= '0;
            act_s0_q    <= CNT_W'(DEF_S0);
            act_s1_q    <= CNT_W'(DEF_S1);
            act_s2_q    <= CNT_W'(DEF_S2);
            act_sr_q    <= CNT_W'(DEF_SR);
            act_freq_q  <= FREQ_8MHZ;
        end else begin
            state_q     <= state_d;
            enable_q    <= (state_d == ST_RUN);
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= (state_d == ST_DONE);
            stop_pend_q <= stop_pend_d;
            count_q     <= count_d;
            if (load) begin
                act_s0_q   <= sh_s0;
                act_s1_q   <= sh_s1;
                act_s2_q   <= sh_s2;
                act_sr_q   <= sh_sr;
                act_freq_q <= sh_freq;
            end
        end
    end

    assign ENABLE        = enable_q;
    assign busy          = busy_q;
    assign ensemble_done = done_q;
    assign pulse_count   = count_q;
    assign freq          = act_freq_q;
    assign State0Value   = act_s0_q;
    assign State1Value   = act_s1_q;
    assign State2Value   = act_s2_q;
    assign StateRValue   = act_sr_q;

endmodule

// File: tb/tb_pulse_sequence_controller.sv
// Randomized bench for pulse_sequence_controller with an in-bench behavioural
// model and a per-cycle compare process, plus directed literal checks.
module tb_pulse_sequence_controller;

    localparam int W = 16;

    logic          coreClock = 1'b0;
    logic          RESET, cfg_wr, start, stop, RETRANSMIT;
    logic [2:0]    cfg_addr;
    logic [W-1:0]  cfg_wdata;
    logic          ENABLE, busy, ensemble_done, cfg_error;
    logic [1:0]    freq;
    logic [W-1:0]  State0Value, State1Value, State2Value, StateRValue, pulse_count;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 coreClock = ~coreClock;

    pulse_sequence_controller dut (
        .coreClock    (coreClock),
        .RESET        (RESET),
        .cfg_wr       (cfg_wr),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .start        (start),
        .stop         (stop),
        .RETRANSMIT   (RETRANSMIT),
        .ENABLE       (ENABLE),
        .freq         (freq),
        .State0Value  (State0Value),
        .State1Value  (State1Value),
        .State2Value  (State2Value),
        .StateRValue  (StateRValue),
        .busy         (busy),
        .ensemble_done(ensemble_done),
        .cfg_error    (cfg_error),
        .pulse_count  (pulse_count)
    );

    // Behavioural model: mode 0 = idle, 1 = running, 2 = ensemble finished.
    int          m_mode;
    int unsigned sh[4];
    int unsigned act[4];
    int unsigned sh_f, act_f, m_n, m_cnt;
    bit          m_pend, m_err, m_sp;

    task automatic model_reset();
        sh     = '{16, 64, 512, 1024};
        act    = '{16, 64, 512, 1024};
        sh_f   = 0;
        act_f  = 0;
        m_n    = 0;
        m_cnt  = 0;
        m_pend = 0;
        m_err  = 0;
        m_sp   = 0;
        m_mode = 0;
    endtask

    function automatic bit shadow_valid();
        bit ok = (sh[0] > 0) && (sh_f != 3);
        for (int i = 0; i < 3; i++)
            if (!(sh[i] < sh[i+1])) ok = 0;
        return ok;
    endfunction

    task automatic model_step();
        bit ld = 0;
        if (RESET) begin
            model_reset();
            return;
        end
        if (m_mode == 0) begin
            if (start && !stop) begin
                ld = m_pend;
                m_cnt = 0;
                m_sp = 0;
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (stop) m_sp = 1;
            if (RETRANSMIT) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_n != 0 && m_cnt == m_n) begin
                    m_mode = 2;
                    m_sp = 0;
                end else if (m_sp) begin
                    m_mode = 0;
                    m_sp = 0;
                end else begin
                    ld = m_pend;
                end
            end
        end else begin
            m_mode = 0;
        end
        if (ld) begin
            act = sh;
            act_f = sh_f;
            m_pend = 0;
        end
        if (cfg_wr) begin
            case (cfg_addr)
                3'd0, 3'd1, 3'd2, 3'd3: sh[cfg_addr] = cfg_wdata;
                3'd4: sh_f = cfg_wdata & 16'h3;
                3'd5: m_n = cfg_wdata;
                3'd6: m_err = 1;
                default: begin
                    if (shadow_valid()) begin
                        m_err = 0;
                        m_pend = 1;
                    end else begin
                        m_err = 1;
                        m_pend = 0;
                    end
                end
            endcase
        end
    endtask

    always @(posedge coreClock) model_step();

    task automatic chk(input string name, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge coreClock) begin
        if (cmp_en) begin
            chk("ENABLE", ENABLE, (m_mode == 1));
            chk("busy", busy, (m_mode != 0));
            chk("ensemble_done", ensemble_done, (m_mode == 2));
            chk("cfg_error", cfg_error, m_err);
            chk("pulse_count", pulse_count, m_cnt);
            chk("freq", freq, act_f);
            chk("State0Value", State0Value, act[0]);
            chk("State1Value", State1Value, act[1]);
            chk("State2Value", State2Value, act[2]);
            chk("StateRValue", StateRValue, act[3]);
        end
    end

    task automatic tick();
        @(posedge coreClock);
        #1;
    endtask

    task automatic wr(input int a, input int unsigned d);
        cfg_wr = 1; cfg_addr = 3'(a); cfg_wdata = W'(d);
        tick();
        cfg_wr = 0;
    endtask

    task automatic pulse();
        RETRANSMIT = 1;
        tick();
        RETRANSMIT = 0;
    endtask

    task automatic do_start();
        start = 1;
        tick();
        start = 0;
    endtask

    initial begin
        RESET = 1; cfg_wr = 0; cfg_addr = 0; cfg_wdata = 0;
        start = 0; stop = 0; RETRANSMIT = 0;
        repeat (2) tick();
        RESET = 0;
        cmp_en = 1;
        chk("lit_reset_enable", ENABLE, 0);
        chk("lit_reset_busy", busy, 0);
        chk("lit_reset_count", pulse_count, 0);
        chk("lit_reset_err", cfg_error, 0);

        // Start: one-cycle latency, defaults on the outputs.
        do_start();
        chk("lit_start_enable", ENABLE, 1);
        chk("lit_start_busy", busy, 1);
        chk("lit_start_s0", State0Value, 16);
        chk("lit_start_s1", State1Value, 64);
        chk("lit_start_s2", State2Value, 512);
        chk("lit_start_sr", StateRValue, 1024);
        chk("lit_start_freq", freq, 0);
        stop = 1; tick(); stop = 0;
        pulse();
        chk("lit_stop_enable", ENABLE, 0);

        // Ensemble of three pulses.
        wr(5, 3);
        do_start();
        for (int i = 1; i <= 3; i++) begin
            tick();
            pulse();
            chk("lit_ens_count", pulse_count, i);
        end
        chk("lit_ens_done", ensemble_done, 1);
        chk("lit_ens_enable", ENABLE, 0);
        tick();
        chk("lit_ens_done_clr", ensemble_done, 0);
        chk("lit_ens_idle", busy, 0);

        // Continuous mode with a mid-run commit applied at the next pulse.
        wr(5, 0);
        do_start();
        wr(0, 32);
        wr(1, 100);
        wr(7, 0);
        repeat (2) tick();
        chk("lit_hold_s0", State0Value, 16);
        pulse();
        chk("lit_apply_s0", State0Value, 32);
        chk("lit_apply_s1", State1Value, 100);

        // Stop mid-pulse waits for the boundary.
        stop = 1; tick(); stop = 0;
        repeat (3) tick();
        chk("lit_stop_hold", ENABLE, 1);
        pulse();
        chk("lit_stop_drop", ENABLE, 0);
        chk("lit_stop_nodone", ensemble_done, 0);

        // Invalid then valid commit.
        wr(0, 50);
        wr(1, 50);
        wr(7, 0);
        chk("lit_bad_commit", cfg_error, 1);
        chk("lit_bad_s0", State0Value, 32);
        wr(1, 60);
        wr(7, 0);
        chk("lit_good_commit", cfg_error, 0);

        // Pending update applied at start, then reset mid-run.
        do_start();
        chk("lit_start_load", State0Value, 50);
        repeat (5) pulse();
        chk("lit_count5", pulse_count, 5);
        RESET = 1; tick(); RESET = 0;
        chk("lit_rst_enable", ENABLE, 0);
        chk("lit_rst_count", pulse_count, 0);
        chk("lit_rst_s0", State0Value, 16);
        chk("lit_rst_s1", State1Value, 64);

        // start with stop stays idle.
        start = 1; stop = 1; tick(); start = 0; stop = 0;
        chk("lit_startstop", busy, 0);

        // Randomized phase.
        repeat (4000) begin
            RESET      = ($urandom_range(0, 499) == 0);
            start      = ($urandom_range(0, 19) == 0);
            stop       = ($urandom_range(0, 39) == 0);
            RETRANSMIT = ($urandom_range(0, 3) == 0);
            cfg_wr     = ($urandom_range(0, 4) == 0);
            cfg_addr   = 3'($urandom_range(0, 7));
            case (cfg_addr)
                3'd4:    cfg_wdata = W'($urandom_range(0, 3));
                3'd5:    cfg_wdata = W'($urandom_range(0, 6));
                3'd6:    cfg_wdata = W'($urandom);
                3'd7:    cfg_wdata = '0;
                default: cfg_wdata = W'($urandom_range(cfg_addr * 300, cfg_addr * 300 + 350));
            endcase
            tick();
        end
        RESET = 0; start = 0; stop = 0; RETRANSMIT = 0; cfg_wr = 0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
